// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants and sync-window helpers
//   Exposes the default porch/sync widths, the derived totals and helper functions
//   (total, sync_start, sync_end, max2) used to size and decode the timing counters.
package vga_timing_pkg;
  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D = 16;
  localparam int H_SYNC_D = 96;
  localparam int H_BP_D = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D = 10;
  localparam int V_SYNC_D = 2;
  localparam int V_BP_D = 33;
  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int sync_start(input int active, input int fp);
    return active + fp;
  endfunction
  function automatic int sync_end(input int active, input int fp, input int sync);
    return active + fp + sync;
  endfunction
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
  localparam int H_TOTAL_D = total(H_ACTIVE_D, H_FP_D, H_SYNC_D, H_BP_D);
  localparam int V_TOTAL_D = total(V_ACTIVE_D, V_FP_D, V_SYNC_D, V_BP_D);
endpackage

// File: rtl/pix_tick_gen.sv
// pix_tick_gen: divides the system clock into one-cycle pixel ticks every CLK_DIV enabled cycles
//   clk, reset_n (sync, active-low), enable (0 holds the divider) -> tick (combinational, one clk wide)
module pix_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
  logic [DW-1:0] div;
  assign tick = enable && (div == LAST);
  always_ff @(posedge clk) begin
    if (!reset_n) div <= '0;
    else if (enable) div <= tick ? '0 : div + DW'(1);
  end
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: parametrised VGA timing generator (hs/vs/bright, x/y, line/frame strobes, frame count)
//   clk, reset_n (sync, active-low), enable (0 freezes everything)
//   hs, vs, bright, pix_tick, x, y, line_start, frame_start, frame_count -- all registered together
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 10,
  parameter int FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic               hs,
  output logic               vs,
  output logic               bright,
  output logic               pix_tick,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);
  localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(sync_start(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(sync_end(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(sync_start(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(sync_end(V_ACTIVE, V_FP, V_SYNC));
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);
  if (CLK_DIV < 1 || CNT_W < $clog2(max2(H_TOTAL, V_TOTAL))) begin : g_bad_params
    $error("vga_sync_gen: CLK_DIV must be >= 1 and CNT_W must hold H_TOTAL-1 and V_TOTAL-1");
  end
  logic tick;
  logic [CNT_W-1:0] x_nxt, y_nxt;
  logic wrap0;
  pix_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .tick(tick)
  );
  always_comb begin
    x_nxt = (x == X_LAST) ? '0 : x + CNT_W'(1);
    y_nxt = (x != X_LAST) ? y : (y == Y_LAST) ? '0 : y + CNT_W'(1);
    wrap0 = (x_nxt == '0) && (y_nxt == '0);
  end
  // Decode from the next-state counters so every output lands on the same edge as x/y.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      x <= X_LAST;
      y <= Y_LAST;
      hs <= ~HS_ON;
      vs <= ~VS_ON;
      bright <= 1'b0;
      pix_tick <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      pix_tick <= tick;
      line_start <= tick && (x_nxt == '0);
      frame_start <= tick && wrap0;
      if (tick) begin
        x <= x_nxt;
        y <= y_nxt;
        hs <= (x_nxt >= HS_BEG && x_nxt < HS_END) ? HS_ON : ~HS_ON;
        vs <= (y_nxt >= VS_BEG && y_nxt < VS_END) ? VS_ON : ~VS_ON;
        bright <= (x_nxt < X_ACT) && (y_nxt < Y_ACT);
        if (wrap0) frame_count <= frame_count + FRAME_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed table on default timing plus model-checked random runs on small geometries
module tb_vga_sync_gen;
  typedef struct packed {
    int x; int y; int hs; int vs; int br; int pt; int ls; int fs; int fc;
  } exp_t;
  typedef struct {
    int rst; int en; int n; exp_t e;
  } row_t;
  typedef struct packed {
    int div; int ha; int hfp; int hsw; int hbp; int va; int vfp; int vsw; int vbp; int hpol; int vpol; int fw;
  } geo_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, en0, rst_s, en_s;
  logic d0_hs, d0_vs, d0_br, d0_pt, d0_ls, d0_fs;
  logic [9:0] d0_x, d0_y;
  logic [15:0] d0_fc;
  logic d1_hs, d1_vs, d1_br, d1_pt, d1_ls, d1_fs;
  logic [3:0] d1_x, d1_y;
  logic [1:0] d1_fc;
  logic d2_hs, d2_vs, d2_br, d2_pt, d2_ls, d2_fs;
  logic [3:0] d2_x, d2_y;
  logic [2:0] d2_fc;

  vga_sync_gen d0 (
    .clk(clk), .reset_n(rst0), .enable(en0), .hs(d0_hs), .vs(d0_vs), .bright(d0_br),
    .pix_tick(d0_pt), .x(d0_x), .y(d0_y), .line_start(d0_ls), .frame_start(d0_fs), .frame_count(d0_fc)
  );
  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CNT_W(4), .FRAME_W(2)
  ) d1 (
    .clk(clk), .reset_n(rst_s), .enable(en_s), .hs(d1_hs), .vs(d1_vs), .bright(d1_br),
    .pix_tick(d1_pt), .x(d1_x), .y(d1_y), .line_start(d1_ls), .frame_start(d1_fs), .frame_count(d1_fc)
  );
  vga_sync_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(0), .VS_POL(1), .CNT_W(4), .FRAME_W(3)
  ) d2 (
    .clk(clk), .reset_n(rst_s), .enable(en_s), .hs(d2_hs), .vs(d2_vs), .bright(d2_br),
    .pix_tick(d2_pt), .x(d2_x), .y(d2_y), .line_start(d2_ls), .frame_start(d2_fs), .frame_count(d2_fc)
  );

  int passed = 0;
  int total_checks = 0;
  int e = 0;
  geo_t g1, g2;
  row_t rows[20];

  function automatic exp_t got0();
    return '{int'(d0_x), int'(d0_y), int'(d0_hs), int'(d0_vs), int'(d0_br), int'(d0_pt), int'(d0_ls), int'(d0_fs), int'(d0_fc)};
  endfunction
  function automatic exp_t got1();
    return '{int'(d1_x), int'(d1_y), int'(d1_hs), int'(d1_vs), int'(d1_br), int'(d1_pt), int'(d1_ls), int'(d1_fs), int'(d1_fc)};
  endfunction
  function automatic exp_t got2();
    return '{int'(d2_x), int'(d2_y), int'(d2_hs), int'(d2_vs), int'(d2_br), int'(d2_pt), int'(d2_ls), int'(d2_fs), int'(d2_fc)};
  endfunction

  function automatic exp_t mk_exp(int x, int y, int hs, int vs, int br, int pt, int ls, int fs, int fc);
    exp_t r;
    r.x = x; r.y = y; r.hs = hs; r.vs = vs; r.br = br; r.pt = pt; r.ls = ls; r.fs = fs; r.fc = fc;
    return r;
  endfunction
  function automatic row_t mk(int rst, int en, int n, exp_t ex);
    row_t r;
    r.rst = rst; r.en = en; r.n = n; r.e = ex;
    return r;
  endfunction

  // Position is derived from how many pixel ticks have elapsed since reset:
  // tick k (1-based) shows raster pixel k-1, counted row-major from (0,0).
  function automatic exp_t model(geo_t g, int en_cnt, int tk);
    exp_t r;
    int ht, vt, t, p;
    ht = g.ha + g.hfp + g.hsw + g.hbp;
    vt = g.va + g.vfp + g.vsw + g.vbp;
    t = en_cnt / g.div;
    if (t == 0) begin
      r.x = ht - 1; r.y = vt - 1; r.fc = 0;
    end else begin
      p = t - 1;
      r.x = p % ht;
      r.y = (p / ht) % vt;
      r.fc = (p / (ht * vt) + 1) % (1 << g.fw);
    end
    r.hs = (r.x >= g.ha + g.hfp && r.x < g.ha + g.hfp + g.hsw) ? g.hpol : 1 - g.hpol;
    r.vs = (r.y >= g.va + g.vfp && r.y < g.va + g.vfp + g.vsw) ? g.vpol : 1 - g.vpol;
    r.br = (r.x < g.ha && r.y < g.va) ? 1 : 0;
    r.pt = tk;
    r.ls = (tk != 0 && r.x == 0) ? 1 : 0;
    r.fs = (r.ls != 0 && r.y == 0) ? 1 : 0;
    return r;
  endfunction

  task automatic chk(string nm, exp_t g, exp_t w);
    total_checks++;
    if (g == w) passed++;
    else $display("FAIL %s: got x=%0d y=%0d hs=%0d vs=%0d br=%0d pt=%0d ls=%0d fs=%0d fc=%0d, want x=%0d y=%0d hs=%0d vs=%0d br=%0d pt=%0d ls=%0d fs=%0d fc=%0d",
                  nm, g.x, g.y, g.hs, g.vs, g.br, g.pt, g.ls, g.fs, g.fc, w.x, w.y, w.hs, w.vs, w.br, w.pt, w.ls, w.fs, w.fc);
  endtask
  task automatic chk_int(string nm, int g, int w);
    total_checks++;
    if (g == w) passed++;
    else $display("FAIL %s: got %0d, want %0d", nm, g, w);
  endtask

  task automatic step_small();
    int tk1, tk2;
    @(posedge clk);
    if (!rst_s) e = 0;
    else if (en_s) e++;
    tk1 = (rst_s && en_s && (e % g1.div == 0)) ? 1 : 0;
    tk2 = (rst_s && en_s && (e % g2.div == 0)) ? 1 : 0;
    #1;
    chk("d1_model", got1(), model(g1, e, tk1));
    chk("d2_model", got2(), model(g2, e, tk2));
  endtask

  initial begin
    int hs_cnt, vs_cnt, br_cnt;
    g1 = '{1, 8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 2};
    g2 = '{3, 8, 2, 2, 2, 4, 1, 1, 1, 0, 1, 3};
    rows[0]  = mk(0, 1, 3,    mk_exp(799, 524, 1, 1, 0, 0, 0, 0, 0));
    rows[1]  = mk(1, 1, 3,    mk_exp(799, 524, 1, 1, 0, 0, 0, 0, 0));
    rows[2]  = mk(1, 1, 1,    mk_exp(0,   0,   1, 1, 1, 1, 1, 1, 1));
    rows[3]  = mk(1, 1, 4,    mk_exp(1,   0,   1, 1, 1, 1, 0, 0, 1));
    rows[4]  = mk(1, 1, 1,    mk_exp(1,   0,   1, 1, 1, 0, 0, 0, 1));
    rows[5]  = mk(1, 1, 2555, mk_exp(640, 0,   1, 1, 0, 1, 0, 0, 1));
    rows[6]  = mk(1, 1, 64,   mk_exp(656, 0,   0, 1, 0, 1, 0, 0, 1));
    rows[7]  = mk(1, 1, 380,  mk_exp(751, 0,   0, 1, 0, 1, 0, 0, 1));
    rows[8]  = mk(1, 1, 4,    mk_exp(752, 0,   1, 1, 0, 1, 0, 0, 1));
    rows[9]  = mk(1, 1, 188,  mk_exp(799, 0,   1, 1, 0, 1, 0, 0, 1));
    rows[10] = mk(1, 1, 4,    mk_exp(0,   1,   1, 1, 1, 1, 1, 0, 1));
    rows[11] = mk(1, 1, 400,  mk_exp(100, 1,   1, 1, 1, 1, 0, 0, 1));
    rows[12] = mk(1, 1, 2,    mk_exp(100, 1,   1, 1, 1, 0, 0, 0, 1));
    rows[13] = mk(1, 0, 10,   mk_exp(100, 1,   1, 1, 1, 0, 0, 0, 1));
    rows[14] = mk(1, 1, 1,    mk_exp(100, 1,   1, 1, 1, 0, 0, 0, 1));
    rows[15] = mk(1, 1, 1,    mk_exp(101, 1,   1, 1, 1, 1, 0, 0, 1));
    rows[16] = mk(1, 1, 796,  mk_exp(300, 1,   1, 1, 1, 1, 0, 0, 1));
    rows[17] = mk(0, 0, 1,    mk_exp(799, 524, 1, 1, 0, 0, 0, 0, 0));
    rows[18] = mk(1, 0, 5,    mk_exp(799, 524, 1, 1, 0, 0, 0, 0, 0));
    rows[19] = mk(1, 1, 4,    mk_exp(0,   0,   1, 1, 1, 1, 1, 1, 1));
    rst_s = 1'b0;
    en_s = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rst0 = rows[i].rst[0];
      en0 = rows[i].en[0];
      repeat (rows[i].n) @(posedge clk);
      #1;
      chk($sformatf("d0_row%0d", i), got0(), rows[i].e);
    end
    step_small();
    rst_s = 1'b1;
    repeat (294) step_small();
    chk_int("d1_3frames_fc", int'(d1_fc), 3);
    chk_int("d1_3frames_x", int'(d1_x), 13);
    chk_int("d1_3frames_y", int'(d1_y), 6);
    repeat (99) step_small();
    chk_int("d1_5frames_fc", int'(d1_fc), 1);
    chk_int("d1_5frames_xy", int'(d1_x) + 16 * int'(d1_y), 0);
    chk_int("d1_5frames_fs", int'(d1_fs), 1);
    rst_s = 1'b0;
    step_small();
    rst_s = 1'b1;
    hs_cnt = 0;
    vs_cnt = 0;
    br_cnt = 0;
    repeat (98) begin
      step_small();
      hs_cnt += int'(d1_hs);
      vs_cnt += int'(d1_vs);
      br_cnt += int'(d1_br);
    end
    chk_int("d1_hs_cycles_per_frame", hs_cnt, 14);
    chk_int("d1_vs_cycles_per_frame", vs_cnt, 14);
    chk_int("d1_bright_cycles_per_frame", br_cnt, 32);
    for (int i = 0; i < 3000; i++) begin
      en_s = ($urandom_range(0, 3) != 0);
      rst_s = ($urandom_range(0, 149) != 0);
      step_small();
    end
    $display("%0d/%0d checks passed", passed, total_checks);
    $finish;
  end
endmodule
